// File: rtl/rv32v_types_pkg.sv
// rv32v_types_pkg: shared types and helpers for the RV32V decode->execute boundary.
package rv32v_types_pkg;
  localparam int DE_MAX_LANES = 8;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} de_state_t;
  function automatic logic [DE_MAX_LANES-1:0] lane_tail_mask(input int elems_left, input int n);
    logic [DE_MAX_LANES-1:0] m;
    for (int i = 0; i < DE_MAX_LANES; i++) m[i] = (i < elems_left) && (i < n);
    return m;
  endfunction
endpackage

// File: rtl/rv32v_de_payload_reg.sv
// rv32v_de_payload_reg: load-enabled payload register with asynchronous clear.
module rv32v_de_payload_reg #(
  parameter int W = 1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge CLK or posedge RST)
    if (RST) q <= '0;
    else if (load) q <= d;
endmodule

// File: rtl/rv32v_decode_execute_stage.sv
// rv32v_decode_execute_stage: decode->execute skid-buffered boundary with tail masking and flush.
// Optional perf counters under RV32V_DE_PERF_EN.
module rv32v_decode_execute_stage
  import rv32v_types_pkg::*;
#(
  parameter int NUM_LANES = 2,
  parameter int LANE_W    = 32,
  parameter int CTRL_W    = 96,
  parameter int OFF_W     = 5
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        flush,
  input  logic                        dec_valid,
  output logic                        dec_ready,
  input  logic [CTRL_W-1:0]           dec_ctrl,
  input  logic [NUM_LANES*LANE_W-1:0] dec_vs1,
  input  logic [NUM_LANES*LANE_W-1:0] dec_vs2,
  input  logic [NUM_LANES*LANE_W-1:0] dec_vs3,
  input  logic [NUM_LANES-1:0]        dec_mask,
  input  logic [NUM_LANES-1:0]        dec_wen,
  input  logic [NUM_LANES*OFF_W-1:0]  dec_woffset,
  input  logic [$clog2(NUM_LANES):0]  dec_elems_left,
  output logic                        ex_valid,
  input  logic                        ex_ready,
  output logic [CTRL_W-1:0]           ex_ctrl,
  output logic [NUM_LANES*LANE_W-1:0] ex_vs1,
  output logic [NUM_LANES*LANE_W-1:0] ex_vs2,
  output logic [NUM_LANES*LANE_W-1:0] ex_vs3,
  output logic [NUM_LANES-1:0]        ex_mask,
  output logic [NUM_LANES-1:0]        ex_wen,
`ifdef RV32V_DE_PERF_EN
  output logic [31:0]                 perf_stall_cnt,
  output logic [31:0]                 perf_full_cnt,
`endif
  output logic [NUM_LANES*OFF_W-1:0]  ex_woffset
);
  localparam int LW = NUM_LANES * LANE_W;
  localparam int PW = CTRL_W + 3 * LW + 2 * NUM_LANES + NUM_LANES * OFF_W;
  de_state_t state_q, state_d;
  logic accept, consume, main_ld, skid_ld;
  logic [DE_MAX_LANES-1:0] tail;
  logic [NUM_LANES-1:0] wen_cap;
  logic [PW-1:0] in_pl, main_d, main_q, skid_q;
  assign dec_ready = state_q != TWO;
  assign ex_valid  = state_q != EMPTY;
  assign accept    = dec_valid & dec_ready;
  assign consume   = ex_valid & ex_ready;
  assign tail      = lane_tail_mask(int'(dec_elems_left), NUM_LANES);
  assign wen_cap   = NUM_LANES'(tail & DE_MAX_LANES'(dec_wen));
  assign in_pl     = {dec_ctrl, dec_vs1, dec_vs2, dec_vs3, dec_mask, wen_cap, dec_woffset};
  assign {ex_ctrl, ex_vs1, ex_vs2, ex_vs3, ex_mask, ex_wen, ex_woffset} = main_q;
  always_comb begin
    main_ld = !flush && ((state_q == EMPTY && accept) || (state_q == ONE && accept && consume) ||
                         (state_q == TWO && consume));
    skid_ld = !flush && state_q == ONE && accept && !consume;
    main_d  = state_q == TWO ? skid_q : in_pl;
    state_d = flush ? EMPTY :
              state_q == EMPTY ? (accept ? ONE : EMPTY) :
              state_q == ONE ? (accept && !consume ? TWO : !accept && consume ? EMPTY : ONE) :
              (consume ? ONE : TWO);
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) state_q <= EMPTY;
    else state_q <= state_d;
  rv32v_de_payload_reg #(.W(PW)) u_main (
    .CLK(CLK), .RST(RST), .load(main_ld), .d(main_d), .q(main_q)
  );
  rv32v_de_payload_reg #(.W(PW)) u_skid (
    .CLK(CLK), .RST(RST), .load(skid_ld), .d(in_pl), .q(skid_q)
  );
`ifdef RV32V_DE_PERF_EN
  logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d, perf_full_cnt_q, perf_full_cnt_d;
  always_comb begin
    perf_stall_cnt_d = (ex_valid && !ex_ready && perf_stall_cnt_q != '1) ? perf_stall_cnt_q + 32'd1 : perf_stall_cnt_q;
    perf_full_cnt_d  = (state_q == TWO && perf_full_cnt_q != '1) ? perf_full_cnt_q + 32'd1 : perf_full_cnt_q;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      perf_stall_cnt_q <= '0;
      perf_full_cnt_q  <= '0;
    end else begin
      perf_stall_cnt_q <= perf_stall_cnt_d;
      perf_full_cnt_q  <= perf_full_cnt_d;
    end
  assign perf_stall_cnt = perf_stall_cnt_q;
  assign perf_full_cnt  = perf_full_cnt_q;
`endif
endmodule

// File: tb/tb_rv32v_decode_execute_stage.sv
// tb_rv32v_decode_execute_stage: directed self-checking bench, NUM_LANES=4.
module tb_rv32v_decode_execute_stage;
  localparam int NL = 4, LW = 32, CW = 96, OW = 5;
  logic CLK = 1'b0, RST = 1'b1, flush = 1'b0, dec_valid = 1'b0, dec_ready, ex_valid, ex_ready = 1'b0;
  logic [CW-1:0] dec_ctrl = '0, ex_ctrl;
  logic [NL*LW-1:0] dec_vs1 = '0, dec_vs2 = '0, dec_vs3 = '0, ex_vs1, ex_vs2, ex_vs3;
  logic [NL-1:0] dec_mask = '0, dec_wen = '0, ex_mask, ex_wen;
  logic [NL*OW-1:0] dec_woffset = '0, ex_woffset;
  logic [2:0] dec_elems_left = 3'd4;
  int checks = 0, failures = 0;
`ifdef RV32V_DE_PERF_EN
  logic [31:0] perf_stall_cnt, perf_full_cnt;
`endif
  rv32v_decode_execute_stage #(.NUM_LANES(NL), .LANE_W(LW), .CTRL_W(CW), .OFF_W(OW)) dut (
    .CLK(CLK), .RST(RST), .flush(flush), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_ctrl(dec_ctrl), .dec_vs1(dec_vs1), .dec_vs2(dec_vs2), .dec_vs3(dec_vs3),
    .dec_mask(dec_mask), .dec_wen(dec_wen), .dec_woffset(dec_woffset),
    .dec_elems_left(dec_elems_left), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_ctrl(ex_ctrl), .ex_vs1(ex_vs1), .ex_vs2(ex_vs2), .ex_vs3(ex_vs3),
    .ex_mask(ex_mask), .ex_wen(ex_wen),
`ifdef RV32V_DE_PERF_EN
    .perf_stall_cnt(perf_stall_cnt), .perf_full_cnt(perf_full_cnt),
`endif
    .ex_woffset(ex_woffset)
  );
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  task automatic push(input logic [31:0] v);
    dec_valid = 1'b1;
    dec_vs1 = {96'd0, v};
    dec_ctrl = {64'd0, v};
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    #12;
    check("rst_ex_valid", ex_valid, 0);
    check("rst_dec_ready", dec_ready, 1);
    check("rst_ex_vs1", ex_vs1, 0);
    check("rst_ex_ctrl", ex_ctrl, 0);
    RST = 1'b0;
    step();
    ex_ready = 1'b1;
    dec_wen = 4'hF;
    for (int k = 0; k < 10; k++) begin
      push(k);
      step();
      check($sformatf("stream_valid%0d", k), ex_valid, 1);
      check($sformatf("stream_vs1_%0d", k), ex_vs1[31:0], k);
      check($sformatf("stream_ready%0d", k), dec_ready, 1);
    end
    dec_valid = 1'b0;
    step();
    check("stream_drain", ex_valid, 0);
    ex_ready = 1'b0;
    push(32'hA);
    step();
    check("bp_a_head", ex_vs1[31:0], 32'hA);
    check("bp_one_ready", dec_ready, 1);
    push(32'hB);
    step();
    check("bp_two_ready", dec_ready, 0);
    check("bp_two_head", ex_vs1[31:0], 32'hA);
    push(32'hC);
    step();
    check("bp_hold_ready", dec_ready, 0);
    check("bp_hold_head", ex_vs1[31:0], 32'hA);
    check("bp_hold_ctrl", ex_ctrl, 96'hA);
    ex_ready = 1'b1;
    step();
    check("bp_out_b", ex_vs1[31:0], 32'hB);
    check("bp_b_ready", dec_ready, 1);
    step();
    check("bp_out_c", ex_vs1[31:0], 32'hC);
    check("bp_c_valid", ex_valid, 1);
    dec_valid = 1'b0;
    step();
    check("bp_empty", ex_valid, 0);
    push(32'h11);
    dec_wen = 4'b1111;
    dec_mask = 4'b1011;
    dec_elems_left = 3'd3;
    step();
    check("tail3_wen", ex_wen, 4'b0111);
    check("tail3_mask", ex_mask, 4'b1011);
    dec_elems_left = 3'd0;
    step();
    check("tail0_wen", ex_wen, 4'b0000);
    check("tail0_valid", ex_valid, 1);
    dec_elems_left = 3'd4;
    step();
    check("tail4_wen", ex_wen, 4'b1111);
    dec_wen = 4'b1010;
    dec_elems_left = 3'd2;
    step();
    check("tail2_wen", ex_wen, 4'b0010);
    dec_elems_left = 3'd1;
    step();
    check("tail1_wen", ex_wen, 4'b0000);
    dec_valid = 1'b0;
    dec_elems_left = 3'd4;
    dec_wen = 4'hF;
    step();
    ex_ready = 1'b0;
    push(32'hD);
    step();
    push(32'hE);
    step();
    check("fl_two_ready", dec_ready, 0);
    push(32'hF);
    flush = 1'b1;
    #1;
    check("fl_cycle_ready", dec_ready, 0);
    step();
    check("fl_valid", ex_valid, 0);
    check("fl_ready", dec_ready, 1);
    check("fl_payload_kept", ex_vs1[31:0], 32'hD);
    flush = 1'b0;
    dec_valid = 1'b0;
    ex_ready = 1'b1;
    step();
    check("fl_no_ghost", ex_valid, 0);
    push(32'h20);
    step();
    check("ar_pre_valid", ex_valid, 1);
    #3 RST = 1'b1;
    #1;
    check("ar_valid", ex_valid, 0);
    check("ar_vs1", ex_vs1, 0);
    check("ar_ctrl", ex_ctrl, 0);
    #2 RST = 1'b0;
    push(32'h30);
    #1;
    check("ar_ready", dec_ready, 1);
    check("ar_idle", ex_valid, 0);
    step();
    check("ar_first_valid", ex_valid, 1);
    check("ar_first_vs1", ex_vs1[31:0], 32'h30);
    dec_valid = 1'b0;
    step();
`ifdef RV32V_DE_PERF_EN
    #2 RST = 1'b1;
    #2 RST = 1'b0;
    ex_ready = 1'b0;
    push(32'h40);
    step();
    push(32'h41);
    step();
    dec_valid = 1'b0;
    for (int k = 0; k < 4; k++) step();
    check("perf_stall", perf_stall_cnt, 5);
    check("perf_full", perf_full_cnt, 4);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("perf_stall_fl", perf_stall_cnt, 6);
    check("perf_full_fl", perf_full_cnt, 5);
    step();
    step();
    check("perf_stall_kept", perf_stall_cnt, 6);
    check("perf_full_kept", perf_full_cnt, 5);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
